// File: rtl/button_conditioner.sv
// Conditions three raw pushbuttons into one-cycle ALU load strobes:
// synchronize, debounce, detect the press edge, and suppress colliding presses.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int NB_CNT          = 20
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_btnA,
    input  logic i_btnB,
    input  logic i_btnOP,
    output logic o_bA,
    output logic o_bB,
    output logic o_bOP,
    output logic o_conflict
);

    localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(DEBOUNCE_CYCLES - 1);

    // Bit 0 = A, bit 1 = B, bit 2 = OP throughout.
    logic [2:0]        raw;
    logic [2:0]        s1;
    logic [2:0]        s2;
    logic [2:0]        stable;
    logic [2:0]        press;
    logic              multi_press;
    logic [NB_CNT-1:0] cnt [3];

    assign raw = {i_btnOP, i_btnB, i_btnA};

    // A press is the edge on which a differing high level completes its count,
    // so the strobe register loads on the same edge that stable rises.
    always_comb begin
        press = '0;
        for (int i = 0; i < 3; i++) begin
            press[i] = s2[i] & ~stable[i] & (cnt[i] == CNT_LAST);
        end
    end

    assign multi_press = |(press & (press - 3'd1));

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            s1     <= '0;
            s2     <= '0;
            stable <= '0;
            for (int i = 0; i < 3; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1 <= raw;
            s2 <= s1;
            for (int i = 0; i < 3; i++) begin
                if (s2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    stable[i] <= s2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + NB_CNT'(1);
                end
            end
        end
    end

    // Colliding presses are consumed here: only the conflict flag fires.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            o_bA       <= 1'b0;
            o_bB       <= 1'b0;
            o_bOP      <= 1'b0;
            o_conflict <= 1'b0;
        end else begin
            o_bA       <= (press == 3'b001);
            o_bB       <= (press == 3'b010);
            o_bOP      <= (press == 3'b100);
            o_conflict <= multi_press;
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: table-driven scenarios, hand-written corner
// sequences, and randomized stimulus against a history-window reference model.
module tb_button_conditioner;

    localparam int D  = 4;
    localparam int NB = 4;

    logic i_clock = 1'b0;
    logic i_reset = 1'b0;
    logic i_btnA  = 1'b0;
    logic i_btnB  = 1'b0;
    logic i_btnOP = 1'b0;
    logic o_bA, o_bB, o_bOP, o_conflict;

    int checks = 0;
    int errors = 0;

    always #5 i_clock = ~i_clock;

    button_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .NB_CNT         (NB)
    ) dut (
        .i_clock   (i_clock),
        .i_reset   (i_reset),
        .i_btnA    (i_btnA),
        .i_btnB    (i_btnB),
        .i_btnOP   (i_btnOP),
        .o_bA      (o_bA),
        .o_bB      (o_bB),
        .o_bOP     (o_bOP),
        .o_conflict(o_conflict)
    );

    // Reference model: a level is accepted once the last D synchronized
    // samples (raw delayed two edges) all disagree with the accepted level.
    logic [2:0] exp_q_unused;
    logic [3:0] exp_q[$];
    logic [2:0] s2_q[$];
    logic [2:0] m_d1, m_d2, m_lvl, m_s2, m_ev;

    initial begin
        m_d1 = '0; m_d2 = '0; m_lvl = '0;
        exp_q_unused = '0;
        forever begin
            @(posedge i_clock);
            if (!i_reset) begin
                m_d1 = '0; m_d2 = '0; m_lvl = '0;
                s2_q.delete();
                exp_q.push_back(4'b0000);
            end else begin
                m_s2 = m_d2;
                m_d2 = m_d1;
                m_d1 = {i_btnOP, i_btnB, i_btnA};
                s2_q.push_back(m_s2);
                if (s2_q.size() > D) void'(s2_q.pop_front());
                m_ev = '0;
                for (int i = 0; i < 3; i++) begin
                    if (s2_q.size() == D) begin
                        bit all_diff;
                        all_diff = 1'b1;
                        foreach (s2_q[j]) if (s2_q[j][i] == m_lvl[i]) all_diff = 1'b0;
                        if (all_diff) begin
                            m_lvl[i] = ~m_lvl[i];
                            m_ev[i]  = m_lvl[i];
                        end
                    end
                end
                case ($countones(m_ev))
                    0:       exp_q.push_back(4'b0000);
                    1:       exp_q.push_back({1'b0, m_ev});
                    default: exp_q.push_back(4'b1000);
                endcase
            end
        end
    end

    initial begin
        logic [3:0] exp;
        logic [3:0] got;
        forever begin
            @(negedge i_clock);
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                got = {o_conflict, o_bOP, o_bB, o_bA};
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL model t=%0t got {conf,op,b,a}=%b expected %b", $time, got, exp);
                end
                checks++;
                if ($countones(got[2:0]) > 1) begin
                    errors++;
                    $display("FAIL onehot t=%0t strobes=%b", $time, got[2:0]);
                end
            end
        end
    end

    typedef struct {
        int a_on, a_off, b_on, b_off, op_on, op_off;
        int exp_a, exp_b, exp_op, exp_c;
    } vec_t;

    vec_t vecs[7];

    task automatic apply_reset();
        i_reset = 1'b0; i_btnA = 1'b0; i_btnB = 1'b0; i_btnOP = 1'b0;
        repeat (3) @(negedge i_clock);
        i_reset = 1'b1;
    endtask

    // Drives the inputs sampled at edge e, then checks the outputs after it.
    task automatic step(input int tag, input int e, input logic rst, input logic a,
                        input logic b, input logic op, input logic [3:0] exp);
        logic [3:0] got;
        i_reset = rst; i_btnA = a; i_btnB = b; i_btnOP = op;
        @(posedge i_clock);
        @(negedge i_clock);
        got = {o_conflict, o_bOP, o_bB, o_bA};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL seq%0d edge %0d: got {conf,op,b,a}=%b expected %b", tag, e, got, exp);
        end
    endtask

    initial begin
        int hold[3];
        logic [2:0] lvl_r;

        vecs[0] = '{10, 60, -1, -1, -1, -1, 15, -1, -1, -1};
        vecs[1] = '{-1, -1, -1, -1, 10, 13, -1, -1, -1, -1};
        vecs[2] = '{10, 60, -1, -1, 10, 60, -1, -1, -1, 15};
        vecs[3] = '{-1, -1, 20, 24, -1, -1, -1, 25, -1, -1};
        vecs[4] = '{10, 60, 11, 60, -1, -1, 15, 16, -1, -1};
        vecs[5] = '{ 5, 60,  5, 60,  5, 60, -1, -1, -1, 10};
        vecs[6] = '{-1, -1, 30, 65, 30, 65, -1, -1, -1, 35};

        foreach (vecs[v]) begin
            apply_reset();
            for (int e = 0; e < 70; e++) begin
                step(v, e, 1'b1,
                     (e >= vecs[v].a_on  && e < vecs[v].a_off),
                     (e >= vecs[v].b_on  && e < vecs[v].b_off),
                     (e >= vecs[v].op_on && e < vecs[v].op_off),
                     {e == vecs[v].exp_c, e == vecs[v].exp_op,
                      e == vecs[v].exp_b, e == vecs[v].exp_a});
            end
        end

        // Bounce on B, then a steady hold from edge 30.
        apply_reset();
        for (int e = 0; e < 60; e++) begin
            logic b;
            b = (e >= 30) || (e == 22) || (e == 23) || (e == 26) || (e == 27);
            step(10, e, 1'b1, 1'b0, b, 1'b0, {2'b00, e == 35, 1'b0});
        end

        // Release and re-press of A.
        apply_reset();
        for (int e = 0; e < 80; e++) begin
            step(11, e, 1'b1, (e >= 10 && e < 30) || (e >= 40), 1'b0, 1'b0,
                 {3'b000, (e == 15) || (e == 45)});
        end

        // Reset mid-count with A still held.
        apply_reset();
        for (int e = 0; e < 40; e++) begin
            step(12, e, e != 12, e >= 10, 1'b0, 1'b0, {3'b000, e == 18});
        end

        // A held across a reset strobes once before and once after it.
        apply_reset();
        for (int e = 0; e < 70; e++) begin
            step(13, e, e != 40, e >= 10, 1'b0, 1'b0, {3'b000, (e == 15) || (e == 46)});
        end

        // Randomized stimulus; the reference model does the checking.
        apply_reset();
        hold[0] = 0; hold[1] = 0; hold[2] = 0;
        lvl_r = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (hold[i] == 0) begin
                    lvl_r[i] = 1'($urandom_range(0, 1));
                    hold[i]  = $urandom_range(1, 8);
                end
                hold[i]--;
            end
            i_btnA  = lvl_r[0];
            i_btnB  = lvl_r[1];
            i_btnOP = lvl_r[2];
            i_reset = ($urandom_range(0, 299) != 0);
            @(negedge i_clock);
        end

        i_reset = 1'b1; i_btnA = 1'b0; i_btnB = 1'b0; i_btnOP = 1'b0;
        repeat (10) @(negedge i_clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
